// File: rtl/issue_scoreboard.sv
// Decode-stage issue control: per-register pending-result counters and
// write-back port reservation, with stall/issue decisions and a stall counter.
module issue_scoreboard #(
  parameter int unsigned REG_ADDR = 5,
  parameter int unsigned LD_LAT   = 2,
  parameter int unsigned MUL_LAT  = 5,
  parameter int unsigned WB_ALU   = 3,
  parameter int unsigned WB_MUL   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_ADDR-1:0] id_src1,
  input  logic [REG_ADDR-1:0] id_src2,
  input  logic                id_use_src1,
  input  logic                id_use_src2,
  input  logic [REG_ADDR-1:0] id_dst,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                id_is_mult,
  input  logic                branch_taken,
  output logic                stall,
  output logic                id_issue,
  output logic [1:0]          wb_owner,
  output logic                busy,
  output logic [15:0]         stall_count
);

  localparam int unsigned NREG = 1 << REG_ADDR;
  localparam int unsigned PW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [PW-1:0] MUL_SET = PW'(MUL_LAT - 1);
  localparam logic [PW-1:0] LD_SET  = PW'(LD_LAT - 1);
  localparam logic [WB_MUL-1:0] ALU_BIT = WB_MUL'(1) << (WB_ALU - 1);
  localparam logic [WB_MUL-1:0] MUL_BIT = WB_MUL'(1) << (WB_MUL - 1);

  // r0 carries no state: the array starts at index 1.
  logic [PW-1:0]     pend_q [1:NREG-1];
  logic [PW-1:0]     pend_d [1:NREG-1];
  logic [WB_MUL-1:0] slot_alu_q, slot_alu_d;
  logic [WB_MUL-1:0] slot_mul_q, slot_mul_d;
  logic [1:0]        wb_owner_q, wb_owner_d;
  logic              busy_q, busy_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic              raw_hit, waw_hit, port_hit;
  logic [WB_MUL-1:0] alu_sh, mul_sh, taken;
  logic              reserve;

  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (pend_q[i] != '0) begin
        if (id_use_src1 && id_src1 == REG_ADDR'(i)) raw_hit = 1'b1;
        if (id_use_src2 && id_src2 == REG_ADDR'(i)) raw_hit = 1'b1;
        if (id_regwrite && id_dst == REG_ADDR'(i))  waw_hit = 1'b1;
      end
    end
  end

  // Port conflict is judged against the vectors as they will look after this edge's shift.
  always_comb begin
    alu_sh   = slot_alu_q >> 1;
    mul_sh   = slot_mul_q >> 1;
    taken    = alu_sh | mul_sh;
    port_hit = id_regwrite & (id_is_mult ? taken[WB_MUL-1] : taken[WB_ALU-1]);
  end

  always_comb begin
    stall    = reset & id_valid & ~branch_taken & (raw_hit | waw_hit | port_hit);
    id_issue = reset & id_valid & ~branch_taken & ~stall;
    reserve  = id_issue & id_regwrite;
  end

  always_comb begin
    busy_d = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      pend_d[i] = (pend_q[i] != '0) ? pend_q[i] - 1'b1 : '0;
      if (reserve && id_dst == REG_ADDR'(i)) begin
        if (id_is_mult)      pend_d[i] = MUL_SET;
        else if (id_memread) pend_d[i] = LD_SET;
        else                 pend_d[i] = '0;
      end
      if (pend_d[i] != '0) busy_d = 1'b1;
    end
  end

  // Bit 0 of the current vectors is the slot that writes back in the coming cycle.
  always_comb begin
    slot_alu_d    = alu_sh | ((reserve && !id_is_mult) ? ALU_BIT : '0);
    slot_mul_d    = mul_sh | ((reserve &&  id_is_mult) ? MUL_BIT : '0);
    wb_owner_d    = {slot_mul_q[0], slot_alu_q[0]};
    stall_count_d = (stall && stall_count_q != '1) ? stall_count_q + 16'd1 : stall_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 1; i < NREG; i++) pend_q[i] <= '0;
      slot_alu_q    <= '0;
      slot_mul_q    <= '0;
      wb_owner_q    <= '0;
      busy_q        <= 1'b0;
      stall_count_q <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) pend_q[i] <= pend_d[i];
      slot_alu_q    <= slot_alu_d;
      slot_mul_q    <= slot_mul_d;
      wb_owner_q    <= wb_owner_d;
      busy_q        <= busy_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign wb_owner    = wb_owner_q;
  assign busy        = busy_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a cycle-by-cycle vector table plus
// hand-written multi-cycle sequences for mul-use, port conflict, WAW and reset.
module tb_issue_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_src1, id_src2, id_dst;
  logic       id_use_src1, id_use_src2;
  logic       id_regwrite, id_memread, id_is_mult, branch_taken;
  logic       stall, id_issue, busy;
  logic [1:0] wb_owner;
  logic [15:0] stall_count;

  int nchk;
  int nfail;

  issue_scoreboard #(
    .REG_ADDR(5), .LD_LAT(2), .MUL_LAT(5), .WB_ALU(3), .WB_MUL(6)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_is_mult(id_is_mult), .branch_taken(branch_taken),
    .stall(stall), .id_issue(id_issue), .wb_owner(wb_owner),
    .busy(busy), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] s1;
    logic       u1;
    logic [4:0] s2;
    logic       u2;
    logic [4:0] dst;
    logic       rw, mr, ml, br;
    logic       e_stall, e_issue;
    logic [1:0] e_wb;
    logic       e_busy;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic v, input logic [4:0] s1, input logic u1,
                              input logic [4:0] s2, input logic u2, input logic [4:0] d,
                              input logic rw, input logic mr, input logic ml, input logic br,
                              input logic es, input logic ei, input logic [1:0] ew,
                              input logic eb);
    vec_t r;
    r.valid = v; r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2; r.dst = d;
    r.rw = rw; r.mr = mr; r.ml = ml; r.br = br;
    r.e_stall = es; r.e_issue = ei; r.e_wb = ew; r.e_busy = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_src1 = v.s1; id_use_src1 = v.u1;
    id_src2 = v.s2; id_use_src2 = v.u2; id_dst = v.dst;
    id_regwrite = v.rw; id_memread = v.mr; id_is_mult = v.ml; branch_taken = v.br;
  endtask

  task automatic drive_nop();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_nop();
    next_cycle();
    reset = 1'b1;
  endtask

  vec_t mul5, rd5, mul7, alu7;

  initial begin
    nchk = 0;
    nfail = 0;
    reset = 1'b0;
    // nop, load r3 / ALU reading r3
    tbl[0]  = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 2'd0, 0);
    tbl[1]  = mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 2'd0, 1);
    tbl[2]  = mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 2'd0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    // load to r0 then reader of r0; branch-killed load r6, reader of r6
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2'd0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 0, 0, 2'd0, 0);
    tbl[11] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0);
    // mul r9, reader under branch, then stalled reader
    tbl[13] = mk(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 1, 2'd0, 0);
    tbl[14] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 1);
    tbl[15] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1);
    tbl[16] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1);
    tbl[17] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1);
    tbl[18] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0);

    mul5 = mk(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0);
    rd5  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    mul7 = mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0, 0);
    alu7 = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, with a valid instruction presented during reset
    drive(rd5);
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_issue", id_issue, 0);
    chk("rst_wb", wb_owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", stall_count, 0);
    next_cycle();
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_issue", i), id_issue, tbl[i].e_issue);
      chk($sformatf("tbl%0d_wb", i), wb_owner, tbl[i].e_wb);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      next_cycle();
    end
    chk("tbl_stall_count", stall_count, 4);

    // Mul-use: 4 stall cycles, wb_owner=10 six edges after the issue edge
    begin
      int stalls, first_wb;
      bit issued;
      stalls = 0; first_wb = -1; issued = 0;
      do_reset();
      drive(mul5);
      #1;
      chk("mul_issue", id_issue, 1);
      next_cycle();
      drive(rd5);
      for (int k = 0; k < 15; k++) begin
        #1;
        if (!issued) begin
          if (id_issue) issued = 1;
          else if (stall) stalls++;
        end
        if (wb_owner == 2'b10 && first_wb < 0) first_wb = k;
        next_cycle();
        if (issued) drive_nop();
      end
      chk("muluse_issued", 32'(issued), 1);
      chk("muluse_stalls", stalls, 4);
      chk("muluse_wb_edge", first_wb, 6);
      chk("muluse_cnt", stall_count, 4);
    end

    // Port conflict: ALU stream behind a mul collides on the 3rd cycle
    begin
      int n, c01, c10;
      logic exp_st;
      n = 0; c01 = 0; c10 = 0;
      do_reset();
      drive(mul5);
      #1;
      chk("port_mul_issue", id_issue, 1);
      next_cycle();
      for (int k = 1; k <= 6; k++) begin
        drive(mk(1, 0, 0, 0, 0, 5'(10 + n), 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        exp_st = (k == 3);
        chk($sformatf("port_c%0d_stall", k), stall, exp_st);
        chk($sformatf("port_c%0d_issue", k), id_issue, !exp_st);
        if (wb_owner == 2'b01) c01++;
        if (wb_owner == 2'b10) c10++;
        chk("port_wb_excl", 32'(wb_owner == 2'b11), 0);
        if (id_issue) n++;
        next_cycle();
      end
      drive_nop();
      for (int k = 0; k < 10; k++) begin
        #1;
        if (wb_owner == 2'b01) c01++;
        if (wb_owner == 2'b10) c10++;
        chk("port_wb_excl", 32'(wb_owner == 2'b11), 0);
        next_cycle();
      end
      chk("port_alu_wbs", c01, 5);
      chk("port_mul_wbs", c10, 1);
    end

    // WAW: ALU write to r7 waits for mul r7; mul writes back first
    begin
      int stalls, nseen;
      bit issued;
      logic [1:0] first_nz, second_nz;
      stalls = 0; nseen = 0; issued = 0; first_nz = 0; second_nz = 0;
      do_reset();
      drive(mul7);
      #1;
      chk("waw_mul_issue", id_issue, 1);
      next_cycle();
      drive(alu7);
      for (int k = 0; k < 15; k++) begin
        #1;
        if (!issued) begin
          if (id_issue) issued = 1;
          else if (stall) stalls++;
        end
        if (wb_owner != 2'b00) begin
          if (nseen == 0) first_nz = wb_owner;
          else if (nseen == 1) second_nz = wb_owner;
          nseen++;
        end
        next_cycle();
        if (issued) drive_nop();
      end
      chk("waw_stalls", stalls, 4);
      chk("waw_nwb", nseen, 2);
      chk("waw_first_wb", first_nz, 2'b10);
      chk("waw_second_wb", second_nz, 2'b01);
    end

    // Reset asserted during a mul-use stall
    do_reset();
    drive(mul5);
    #1;
    chk("rmid_mul_issue", id_issue, 1);
    next_cycle();
    drive(rd5);
    #1;
    chk("rmid_stall1", stall, 1);
    next_cycle();
    #1;
    chk("rmid_stall2", stall, 1);
    chk("rmid_busy_pre", busy, 1);
    chk("rmid_cnt_pre", stall_count, 1);
    reset = 1'b0;
    #1;
    chk("rmid_stall", stall, 0);
    chk("rmid_issue", id_issue, 0);
    chk("rmid_wb", wb_owner, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_cnt", stall_count, 0);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("rmid_post_stall", stall, 0);
    chk("rmid_post_issue", id_issue, 1);
    next_cycle();
    drive_nop();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
